hazard_sequencer: RTL and testbench

Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB). It consumes the per-instruction decode outputs of the ID stage and keeps a small scoreboard of the instructions in EX, MEM and WB. From that it drives the pipeline-register enables, flushes, PC redirect select and EX-stage operand forwarding selects. It also freezes the pipeline while the data memory is busy, with a watchdog on that wait.

---
 rtl/hazard_sequencer.sv | 176 +++++++++++++++++
 tb/tb_hazard_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: EX/MEM/WB scoreboard driving stalls, flushes,
// PC redirect, operand forwarding and a watchdog on data-memory waits.
module hazard_sequencer #(
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_wr,
  input  logic              id_load,
  input  logic              id_store,
  input  logic              id_jump,
  input  logic              id_branch,
  input  logic              ex_taken,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_en,
  output logic [1:0]        redirect_sel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_req,
  output logic              mem_err,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              reg_wr;
    logic              load;
    logic              store;
    logic              branch;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic              use_a;
    logic              use_b;
  } slot_t;

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  slot_t          id_slot, ex_q, mem_q, wb_q;
  state_e         state_q, state_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic [15:0]    stall_q, stall_d;
  logic           err_q;
  logic           lu, bt, freeze, timeout;
  logic [1:0]     lost;
  logic [16:0]    stall_sum;
  logic           unused_wb_bits;

  assign id_slot = '{valid: id_valid, dest: id_dest, reg_wr: id_reg_wr, load: id_load,
                     store: id_store, branch: id_branch, src_a: id_src_a, src_b: id_src_b,
                     use_a: id_use_a, use_b: id_use_b};

  // WB only ever supplies a destination for forwarding.
  assign unused_wb_bits = ^{wb_q.load, wb_q.store, wb_q.branch, wb_q.src_a, wb_q.src_b,
                            wb_q.use_a, wb_q.use_b};

  function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, slot_t wb,
                                         logic [REG_AW-1:0] src, logic use_src);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex.valid && use_src) begin
      if (mem.valid && mem.reg_wr && mem.dest != '0 && mem.dest == src) begin
        sel = 2'b01;
      end else if (wb.valid && wb.reg_wr && wb.dest != '0 && wb.dest == src) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  assign mem_req = mem_q.valid & (mem_q.load | mem_q.store);
  assign timeout = (state_q == StMemWait) & mem_req & ~mem_ready & (wait_q == CW'(TIMEOUT));
  assign freeze  = mem_req & ~mem_ready & ~timeout;

  assign lu = ex_q.valid & ex_q.load & ex_q.reg_wr & (ex_q.dest != '0) & id_valid &
              ((id_use_a & (id_src_a == ex_q.dest)) | (id_use_b & (id_src_b == ex_q.dest)));
  assign bt = ex_q.valid & ex_q.branch & ex_taken;

  assign fwd_a     = fwd_sel(ex_q, mem_q, wb_q, ex_q.src_a, ex_q.use_a);
  assign fwd_b     = fwd_sel(ex_q, mem_q, wb_q, ex_q.src_b, ex_q.use_b);
  assign mem_err   = err_q;
  assign stall_cnt = stall_q;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    pipe_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    redirect_sel = 2'b00;
    if (freeze) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (bt) begin
      redirect_sel = 2'b10;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump && id_valid) begin
      redirect_sel = 2'b01;
      ifid_flush   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRun: begin
        if (mem_req && !mem_ready) begin
          state_d = StMemWait;
          wait_d  = CW'(1);
        end
      end
      StMemWait: begin
        if (mem_ready || timeout || !mem_req) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  // Each flushed stage is one lost slot, so a taken branch costs two.
  always_comb begin
    lost      = freeze ? 2'd1 : ({1'b0, ifid_flush} + {1'b0, idex_flush});
    stall_sum = {1'b0, stall_q} + 17'(lost);
    stall_d   = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= StRun;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_q | timeout;
      if (pipe_en) begin
        ex_q  <= idex_flush ? '0 : id_slot;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized
// decode streams checked against a slot-list reference model.
module tb_hazard_sequencer;

  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_a, id_use_b, id_reg_wr, id_load, id_store;
  logic          id_jump, id_branch, ex_taken, mem_ready;
  logic [AW-1:0] id_src_a, id_src_b, id_dest;
  logic          pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, mem_req, mem_err;
  logic [1:0]    redirect_sel, fwd_a, fwd_b;
  logic [15:0]   stall_cnt;

  int errors = 0;
  int checks = 0;

  hazard_sequencer #(.REG_AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_dest(id_dest), .id_reg_wr(id_reg_wr),
    .id_load(id_load), .id_store(id_store), .id_jump(id_jump), .id_branch(id_branch),
    .ex_taken(ex_taken), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_en(pipe_en),
    .redirect_sel(redirect_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_req(mem_req),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, redirect_sel}
  wire [6:0] ctrl = {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, redirect_sel};
  localparam logic [6:0] CtlRun    = 7'b111_00_00;
  localparam logic [6:0] CtlLu     = 7'b001_01_00;
  localparam logic [6:0] CtlBranch = 7'b111_11_10;
  localparam logic [6:0] CtlJump   = 7'b111_10_01;
  localparam logic [6:0] CtlFreeze = 7'b000_00_00;

  typedef struct {
    bit          valid;
    bit [AW-1:0] dest;
    bit          reg_wr, load, store, branch;
    bit [AW-1:0] src_a, src_b;
    bit          use_a, use_b;
  } mslot_t;

  mslot_t pipe_m[3];  // 0 = EX, 1 = MEM, 2 = WB

  task automatic clear_id();
    id_valid = 0; id_src_a = '0; id_src_b = '0; id_use_a = 0; id_use_b = 0; id_dest = '0;
    id_reg_wr = 0; id_load = 0; id_store = 0; id_jump = 0; id_branch = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; clear_id(); ex_taken = 0; mem_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_id(); ex_taken = 0; mem_ready = 1;
    @(negedge clk); #1;
    checks++;
    if ({ctrl, fwd_a, fwd_b, mem_req, mem_err, stall_cnt} !== {CtlRun, 4'b0, 2'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got ctrl=%b fwd=%b%b req=%b err=%b stall=%0d",
               ctrl, fwd_a, fwd_b, mem_req, mem_err, stall_cnt);
    end
    rst = 0;
    step(); #1;
    checks++;
    if ({ctrl, mem_req, stall_cnt} !== {CtlRun, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_idle: got ctrl=%b req=%b stall=%0d", ctrl, mem_req, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1; id_dest = 2; id_reg_wr = 1; id_load = 1; id_use_a = 1; id_src_a = 1;
    #1;
    checks++;
    if (ctrl !== CtlRun) begin errors++; $display("FAIL lu_load_issue: got %b exp %b", ctrl, CtlRun); end
    step(); clear_id();
    id_valid = 1; id_dest = 3; id_reg_wr = 1; id_src_a = 2; id_use_a = 1; id_src_b = 1; id_use_b = 1;
    #1;
    checks++;
    if (ctrl !== CtlLu) begin errors++; $display("FAIL lu_stall: got %b exp %b", ctrl, CtlLu); end
    step(); #1;
    checks++;
    if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt); end
    checks++;
    if ({ctrl, mem_req} !== {CtlRun, 1'b1}) begin
      errors++; $display("FAIL lu_resume: got ctrl=%b req=%b exp %b 1", ctrl, mem_req, CtlRun);
    end
    step(); clear_id(); #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b10_00) begin
      errors++; $display("FAIL lu_fwd_wb: got a=%b b=%b exp a=10 b=00", fwd_a, fwd_b);
    end
  endtask

  task automatic test_forward_ex_mem();
    do_reset();
    id_valid = 1; id_dest = 1; id_reg_wr = 1; id_src_a = 5; id_src_b = 6; id_use_a = 1; id_use_b = 1;
    step(); clear_id();
    id_valid = 1; id_dest = 4; id_reg_wr = 1; id_src_a = 1; id_src_b = 1; id_use_a = 1; id_use_b = 1;
    #1;
    checks++;
    if (ctrl !== CtlRun) begin errors++; $display("FAIL fwd_no_stall: got %b exp %b", ctrl, CtlRun); end
    step(); clear_id(); #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b01_01) begin
      errors++; $display("FAIL fwd_mem: got a=%b b=%b exp a=01 b=01", fwd_a, fwd_b);
    end
  endtask

  task automatic test_branch_and_jump();
    do_reset();
    // Load and branch in one slot so load-use and taken-branch coincide.
    id_valid = 1; id_dest = 2; id_reg_wr = 1; id_load = 1; id_branch = 1;
    step(); clear_id();
    id_valid = 1; id_dest = 3; id_reg_wr = 1; id_src_a = 2; id_use_a = 1; id_jump = 1;
    ex_taken = 1; #1;
    checks++;
    if (ctrl !== CtlBranch) begin errors++; $display("FAIL bt_over_lu: got %b exp %b", ctrl, CtlBranch); end
    step(); ex_taken = 0; clear_id(); #1;
    checks++;
    if (stall_cnt !== 16'd2) begin errors++; $display("FAIL bt_stall_cnt: got %0d exp 2", stall_cnt); end
    checks++;
    if (ctrl !== CtlRun) begin errors++; $display("FAIL bt_after: got %b exp %b", ctrl, CtlRun); end
    id_valid = 1; id_jump = 1; #1;
    checks++;
    if (ctrl !== CtlJump) begin errors++; $display("FAIL jump: got %b exp %b", ctrl, CtlJump); end
    step(); clear_id(); #1;
    checks++;
    if (stall_cnt !== 16'd3) begin errors++; $display("FAIL jump_stall_cnt: got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    id_valid = 1; id_store = 1; id_src_a = 1; id_src_b = 2; id_use_a = 1; id_use_b = 1;
    step(); clear_id();
    step(); mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ctrl, mem_req} !== {CtlFreeze, 1'b1}) begin
        errors++; $display("FAIL mem_freeze[%0d]: got ctrl=%b req=%b exp %b 1", i, ctrl, mem_req, CtlFreeze);
      end
      step();
    end
    mem_ready = 1; #1;
    checks++;
    if ({ctrl, mem_req} !== {CtlRun, 1'b1}) begin
      errors++; $display("FAIL mem_release: got ctrl=%b req=%b exp %b 1", ctrl, mem_req, CtlRun);
    end
    checks++;
    if (stall_cnt !== 16'd3) begin errors++; $display("FAIL mem_stall_cnt: got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    id_valid = 1; id_dest = 5; id_reg_wr = 1; id_load = 1;
    step(); clear_id();
    step(); mem_ready = 0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      #1;
      checks++;
      if (pipe_en !== 1'b0) begin errors++; $display("FAIL to_freeze[%0d]: got pipe_en=%b exp 0", i, pipe_en); end
      step();
    end
    #1;
    checks++;
    if ({pipe_en, mem_err} !== 2'b10) begin
      errors++; $display("FAIL to_release: got pipe_en=%b err=%b exp 1 0", pipe_en, mem_err);
    end
    step(); #1;
    checks++;
    if ({mem_err, mem_req, stall_cnt} !== {1'b1, 1'b0, 16'(TIMEOUT)}) begin
      errors++; $display("FAIL to_err: got err=%b req=%b stall=%0d exp 1 0 %0d", mem_err, mem_req,
                         stall_cnt, TIMEOUT);
    end
    repeat (3) step();
    #1;
    checks++;
    if (mem_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", mem_err); end
    rst = 1; #1;
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL to_rst_clear: got %b exp 0", mem_err); end
    step(); rst = 0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    id_valid = 1; id_store = 1; id_src_a = 3; id_use_a = 1;
    step(); clear_id();
    step(); mem_ready = 0;
    step(); step();
    rst = 1; #1;
    checks++;
    if ({mem_req, pc_en, stall_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL rst_mid_async: got req=%b pc_en=%b stall=%0d exp 0 1 0", mem_req, pc_en, stall_cnt);
    end
    step(); rst = 0; #1;
    checks++;
    if ({mem_req, pc_en, stall_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL rst_mid_after: got req=%b pc_en=%b stall=%0d exp 0 1 0", mem_req, pc_en, stall_cnt);
    end
  endtask

  function automatic bit [1:0] model_fwd(bit [AW-1:0] src, bit use_src);
    if (!pipe_m[0].valid || !use_src) return 2'b00;
    for (int s = 1; s < 3; s++) begin
      if (pipe_m[s].valid && pipe_m[s].reg_wr && pipe_m[s].dest != 0 && pipe_m[s].dest == src)
        return 2'(s);
    end
    return 2'b00;
  endfunction

  task automatic test_random(int n);
    int     m_wait, m_stall, lost_slots;
    bit     m_err;
    do_reset();
    for (int s = 0; s < 3; s++) pipe_m[s] = '{default: 0};
    m_wait = 0; m_stall = 0; m_err = 0;
    for (int c = 0; c < n; c++) begin
      bit         mreq, frz, tmo, lu, bt, e_pc, e_ifid, e_pipe, e_iff, e_idf;
      bit [1:0]   e_red;
      bit [12:0]  exp_v, obs_v;
      mslot_t     ex, nxt;
      id_valid  = ($urandom_range(0, 3) != 0);
      id_src_a  = AW'($urandom_range(0, 7));
      id_src_b  = AW'($urandom_range(0, 7));
      id_dest   = AW'($urandom_range(0, 7));
      id_use_a  = ($urandom_range(0, 1) == 1);
      id_use_b  = ($urandom_range(0, 1) == 1);
      id_reg_wr = ($urandom_range(0, 3) != 0);
      id_load   = ($urandom_range(0, 3) == 0);
      id_store  = ($urandom_range(0, 5) == 0);
      id_branch = ($urandom_range(0, 7) == 0);
      id_jump   = ($urandom_range(0, 9) == 0);
      ex_taken  = ($urandom_range(0, 1) == 1);
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      ex   = pipe_m[0];
      mreq = pipe_m[1].valid && (pipe_m[1].load || pipe_m[1].store);
      frz  = mreq && !mem_ready && m_wait < int'(TIMEOUT);
      tmo  = mreq && !mem_ready && m_wait >= int'(TIMEOUT);
      lu   = ex.valid && ex.load && ex.reg_wr && ex.dest != 0 && id_valid &&
             ((id_use_a && id_src_a == ex.dest) || (id_use_b && id_src_b == ex.dest));
      bt   = ex.valid && ex.branch && ex_taken;
      {e_pc, e_ifid, e_pipe, e_iff, e_idf, e_red} = CtlRun;
      if (frz)                      {e_pc, e_ifid, e_pipe, e_iff, e_idf, e_red} = CtlFreeze;
      else if (bt)                  {e_pc, e_ifid, e_pipe, e_iff, e_idf, e_red} = CtlBranch;
      else if (lu)                  {e_pc, e_ifid, e_pipe, e_iff, e_idf, e_red} = CtlLu;
      else if (id_jump && id_valid) {e_pc, e_ifid, e_pipe, e_iff, e_idf, e_red} = CtlJump;
      exp_v = {e_pc, e_ifid, e_pipe, e_iff, e_idf, e_red, model_fwd(ex.src_a, ex.use_a),
               model_fwd(ex.src_b, ex.use_b), mreq, m_err};
      obs_v = {ctrl, fwd_a, fwd_b, mem_req, mem_err};
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL rand_outputs cyc %0d: got %b exp %b", c, obs_v, exp_v);
      end
      checks++;
      if (stall_cnt !== 16'(m_stall)) begin
        errors++; $display("FAIL rand_stall cyc %0d: got %0d exp %0d", c, stall_cnt, m_stall);
      end
      lost_slots = frz ? 1 : int'(e_iff) + int'(e_idf);
      m_stall    = (m_stall + lost_slots > 65535) ? 65535 : m_stall + lost_slots;
      m_wait     = frz ? m_wait + 1 : 0;
      if (tmo) m_err = 1;
      if (e_pipe) begin
        nxt = '{valid: id_valid, dest: id_dest, reg_wr: id_reg_wr, load: id_load, store: id_store,
                branch: id_branch, src_a: id_src_a, src_b: id_src_b, use_a: id_use_a,
                use_b: id_use_b};
        pipe_m[2] = pipe_m[1];
        pipe_m[1] = pipe_m[0];
        pipe_m[0] = e_idf ? '{default: 0} : nxt;
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward_ex_mem();
    test_branch_and_jump();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
